gray_counter_tx: RTL and testbench
==================================

// Module: gray_counter_tx
// PURPOSE
//  Sequential binary-to-Gray encoder/transmitter: keeps a WIDTH-bit binary count
//  and emits its Gray code on a valid/ready stream, advancing one step per accepted word.
//  Inverse end of the Gray-to-binary decode path; feeds downstream consumers or
//  clock-domain crossings that need single-bit-change sequences.
// PARAMETERS
//  WIDTH  4  count / code width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  en          in   1      run request; 1 = stream codes
//  up          in   1      direction: 1 = increment, 0 = decrement (sampled on transfer)
//  load        in   1      synchronous load strobe
//  load_bin    in   WIDTH  binary value loaded when load=1
//  gray_out    out  WIDTH  registered Gray code of bin_out
//  gray_valid  out  1      gray_out holds a word offered to the consumer
//  gray_ready  in   1      consumer accepts gray_out this cycle
//  bin_out     out  WIDTH  registered internal binary count
//  wrap        out  1      1-cycle pulse: last advance crossed max<->0
// BEHAVIOUR
//  - Reset (rst_n=0, async): bin_out=0, gray_out=0, gray_valid=0, wrap=0, state IDLE.
//  - Invariant: gray_out == bin_out ^ (bin_out>>1) on every cycle; both registers
//    update on the same edge; gray_out is never driven combinationally.
//  - Transfer = gray_valid & gray_ready at a rising edge.
//  - FSM states IDLE (gray_valid=0), RUN (gray_valid=1):
//    IDLE: en=1 -> RUN; gray_valid=1 next cycle (latency 1), count unchanged.
//          en=0 -> stay IDLE.
//    RUN: no transfer -> hold gray_out, bin_out, gray_valid stable; en and up ignored.
//         transfer -> bin_out <= bin_out+1 (up=1) or -1 (up=0), mod 2^WIDTH;
//                     gray_out updated accordingly;
//                     stay RUN if en=1, else -> IDLE (gray_valid=0 next cycle).
//  - en deasserted while stalled: valid stays high until the pending word transfers,
//    then -> IDLE.
//  - load: highest priority, any state. Next cycle: bin_out=load_bin,
//    gray_out=Gray(load_bin), gray_valid=0, state IDLE, wrap=0.
//    Any pending word is dropped; this is the only legal valid withdrawal.
//  - wrap: registered; 1 for exactly the cycle after a transfer that moves
//    (2^WIDTH-1)->0 (up) or 0->(2^WIDTH-1) (down); 0 otherwise.
//  - Consecutive accepted words differ in exactly one bit, including across wrap
//    and direction changes. Load breaks this property.
// TESTING
//  1 WIDTH=4, en=1, up=1, ready=1 from reset -> accepted 0000,0001,0011,0010,0110,...,
//    1000,0000; wrap pulses once after 1000->0000; every pair of words differs in 1 bit.
//  2 From reset, up=0 -> first word 0000, then 1000 (bin 15); wrap pulses once.
//  3 RUN at bin 5 (gray 0111), ready=0 for 3 cycles, en dropped -> gray_out=0111 and
//    valid=1 held; ready=1 -> bin 6 (0101) registered, then valid=0, state IDLE.
//  4 load=1, load_bin=1010 during RUN -> next cycle valid=0, bin_out=1010,
//    gray_out=1111; en=1 -> first word 1111, then 1110 (up).
//  5 rst_n low mid-RUN at bin 9 -> all outputs 0 immediately, with no clock edge;
//    release, en=1 -> stream restarts at 0000.
//  6 Random en/up/ready/load, 10k cycles -> bench Gray-to-binary model of gray_out
//    equals bin_out every cycle; no valid drop without transfer or load.

Source files
------------

// File: rtl/gray_counter_tx.sv
// Binary up/down counter whose Gray code is offered on a valid/ready stream;
// the count advances by one step for every word the consumer accepts.
module gray_counter_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] gray_out,
   output logic             gray_valid,
   input  logic             gray_ready,
   output logic [WIDTH-1:0] bin_out,
   output logic             wrap
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_reg;
   logic [WIDTH-1:0] bin_reg;
   logic [WIDTH-1:0] gray_reg;
   logic             valid_reg;
   logic             wrap_reg;

   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_next;
   logic             transfer;

   assign transfer = valid_reg & gray_ready;

   always_comb begin
      bin_next = bin_reg;
      if (load)
         bin_next = load_bin;
      else if (transfer)
         bin_next = up ? bin_reg + ONE : bin_reg - ONE;
   end

   assign wrap_next = ~load & transfer & (up ? (&bin_reg) : ~(|bin_reg));

   // Gray code is derived from the next binary value so both registers load on the same edge
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
         assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
      end
   endgenerate
   assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         bin_reg   <= '0;
         gray_reg  <= '0;
         valid_reg <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         bin_reg  <= bin_next;
         gray_reg <= gray_next;
         wrap_reg <= wrap_next;
         if (load) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (en) begin
                     state_reg <= RUN;
                     valid_reg <= 1'b1;
                  end
               end
               RUN: begin
                  // Valid only drops once the pending word has been taken
                  if (transfer && !en) begin
                     state_reg <= IDLE;
                     valid_reg <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign gray_out   = gray_reg;
   assign gray_valid = valid_reg;
   assign bin_out    = bin_reg;
   assign wrap       = wrap_reg;

endmodule

// File: tb/tb_gray_counter_tx.sv
// Bench for gray_counter_tx: directed scenarios plus a long random run, all
// checked against an arithmetic model of the count, the valid flag and wrap.
module tb_gray_counter_tx;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_bin;
   logic [W-1:0] gray_out;
   logic         gray_valid;
   logic         gray_ready;
   logic [W-1:0] bin_out;
   logic         wrap;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_bin;
   bit m_valid;
   bit m_wrap;

   logic [W-1:0] acc_q[$];

   always #5 clk = ~clk;

   gray_counter_tx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_bin  (load_bin),
      .gray_out  (gray_out),
      .gray_valid(gray_valid),
      .gray_ready(gray_ready),
      .bin_out   (bin_out),
      .wrap      (wrap)
   );

   function automatic logic [W-1:0] to_gray(input int b);
      int v;
      v = b % MOD;
      return W'(v ^ (v >> 1));
   endfunction

   function automatic int gray_to_bin(input logic [W-1:0] g);
      int b;
      int acc;
      b = 0;
      acc = 0;
      for (int i = W - 1; i >= 0; i--) begin
         acc = acc ^ int'(g[i]);
         b = b | (acc << i);
      end
      return b;
   endfunction

   function automatic int ones(input logic [W-1:0] x);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) n += int'(x[i]);
      return n;
   endfunction

   // One clock: note an accepted word, advance the model, return at the negedge.
   task automatic cycle();
      bit           t;
      int           old;
      logic [W-1:0] g;
      t = (gray_valid === 1'b1) && (gray_ready === 1'b1);
      g = gray_out;
      if (t) acc_q.push_back(g);
      @(posedge clk);
      if (load) begin
         m_bin   = int'(load_bin);
         m_valid = 1'b0;
         m_wrap  = 1'b0;
      end else if (!m_valid) begin
         m_wrap  = 1'b0;
         m_valid = en;
      end else if (gray_ready) begin
         old     = m_bin;
         m_bin   = (m_bin + (up ? 1 : MOD - 1)) % MOD;
         m_wrap  = (up && old == MOD - 1) || (!up && old == 0);
         m_valid = en;
      end else begin
         m_wrap = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_bin   = 0;
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      en = 0; up = 1; load = 0; load_bin = '0; gray_ready = 0;
      do_reset();
      vectors += 4;
      if (bin_out !== '0) begin miscompares++; $display("FAIL reset_bin got %b want 0000", bin_out); end
      if (gray_out !== '0) begin miscompares++; $display("FAIL reset_gray got %b want 0000", gray_out); end
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", gray_valid); end
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got %b want 0", wrap); end
      cycle();
      vectors++;
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL idle_hold_valid got %b want 0", gray_valid); end
   endtask

   task automatic test_up_count();
      int wraps;
      do_reset();
      en = 1; up = 1; gray_ready = 1;
      acc_q.delete();
      wraps = 0;
      repeat (18) begin
         cycle();
         if (wrap === 1'b1) wraps++;
         vectors += 3;
         if (bin_out !== W'(m_bin)) begin miscompares++; $display("FAIL up_bin got %0d want %0d", bin_out, m_bin); end
         if (gray_out !== to_gray(m_bin)) begin miscompares++; $display("FAIL up_gray got %b want %b", gray_out, to_gray(m_bin)); end
         if (wrap !== m_wrap) begin miscompares++; $display("FAIL up_wrap got %b want %b", wrap, m_wrap); end
      end
      vectors += 2;
      if (wraps != 1) begin miscompares++; $display("FAIL up_wrap_count got %0d want 1", wraps); end
      if (acc_q.size() != 17) begin
         miscompares++; $display("FAIL up_word_count got %0d want 17", acc_q.size());
      end else begin
         for (int i = 0; i < 17; i++) begin
            vectors++;
            if (acc_q[i] !== to_gray(i)) begin miscompares++; $display("FAIL up_word[%0d] got %b want %b", i, acc_q[i], to_gray(i)); end
            if (i > 0) begin
               vectors++;
               if (ones(acc_q[i] ^ acc_q[i-1]) != 1) begin miscompares++; $display("FAIL up_onebit[%0d] got %b after %b", i, acc_q[i], acc_q[i-1]); end
            end
         end
      end
   endtask

   task automatic test_down_count();
      int wraps;
      do_reset();
      en = 1; up = 0; gray_ready = 1;
      acc_q.delete();
      wraps = 0;
      repeat (4) begin
         cycle();
         if (wrap === 1'b1) wraps++;
      end
      vectors += 4;
      if (wraps != 1) begin miscompares++; $display("FAIL down_wrap_count got %0d want 1", wraps); end
      if (acc_q.size() < 2) begin
         miscompares++; $display("FAIL down_word_count got %0d want >=2", acc_q.size());
      end else begin
         if (acc_q[0] !== 4'b0000) begin miscompares++; $display("FAIL down_word0 got %b want 0000", acc_q[0]); end
         if (acc_q[1] !== 4'b1000) begin miscompares++; $display("FAIL down_word1 got %b want 1000", acc_q[1]); end
      end
      if (bin_out !== 4'd13) begin miscompares++; $display("FAIL down_bin got %0d want 13", bin_out); end
   endtask

   task automatic test_stall();
      do_reset();
      en = 1; up = 1; gray_ready = 1;
      repeat (6) cycle();
      vectors++;
      if (bin_out !== 4'd5) begin miscompares++; $display("FAIL stall_start_bin got %0d want 5", bin_out); end
      gray_ready = 0; en = 0;
      repeat (3) begin
         cycle();
         vectors += 3;
         if (gray_out !== 4'b0111) begin miscompares++; $display("FAIL stall_gray got %b want 0111", gray_out); end
         if (gray_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", gray_valid); end
         if (bin_out !== 4'd5) begin miscompares++; $display("FAIL stall_bin got %0d want 5", bin_out); end
      end
      gray_ready = 1;
      cycle();
      vectors += 3;
      if (bin_out !== 4'd6) begin miscompares++; $display("FAIL stall_release_bin got %0d want 6", bin_out); end
      if (gray_out !== 4'b0101) begin miscompares++; $display("FAIL stall_release_gray got %b want 0101", gray_out); end
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release_valid got %b want 0", gray_valid); end
      cycle();
      vectors++;
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL stall_idle_valid got %b want 0", gray_valid); end
   endtask

   task automatic test_load();
      en = 1; up = 1; gray_ready = 1;
      cycle();
      load = 1; load_bin = 4'b1010;
      cycle();
      load = 0;
      vectors += 4;
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL load_valid got %b want 0", gray_valid); end
      if (bin_out !== 4'b1010) begin miscompares++; $display("FAIL load_bin got %b want 1010", bin_out); end
      if (gray_out !== 4'b1111) begin miscompares++; $display("FAIL load_gray got %b want 1111", gray_out); end
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL load_wrap got %b want 0", wrap); end
      acc_q.delete();
      repeat (3) cycle();
      vectors++;
      if (acc_q.size() < 2) begin
         miscompares++; $display("FAIL load_word_count got %0d want >=2", acc_q.size());
      end else begin
         vectors++;
         if (acc_q[0] !== 4'b1111) begin miscompares++; $display("FAIL load_word0 got %b want 1111", acc_q[0]); end
         if (acc_q[1] !== 4'b1110) begin miscompares++; $display("FAIL load_word1 got %b want 1110", acc_q[1]); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      en = 1; up = 1; gray_ready = 1;
      repeat (10) cycle();
      vectors++;
      if (bin_out !== 4'd9) begin miscompares++; $display("FAIL areset_pre_bin got %0d want 9", bin_out); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors += 4;
      if (bin_out !== '0) begin miscompares++; $display("FAIL areset_bin got %b want 0000", bin_out); end
      if (gray_out !== '0) begin miscompares++; $display("FAIL areset_gray got %b want 0000", gray_out); end
      if (gray_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %b want 0", gray_valid); end
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL areset_wrap got %b want 0", wrap); end
      m_bin = 0; m_valid = 0; m_wrap = 0;
      @(negedge clk);
      rst_n = 1'b1;
      acc_q.delete();
      repeat (3) cycle();
      vectors++;
      if (acc_q.size() < 1 || acc_q[0] !== 4'b0000) begin
         miscompares++; $display("FAIL areset_restart got %0d words, first %b want 0000", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 4'bxxxx);
      end
   endtask

   task automatic test_random();
      bit           p_valid, p_ready, p_load;
      logic [W-1:0] p_gray;
      do_reset();
      acc_q.delete();
      for (int n = 0; n < 10000; n++) begin
         en         = ($urandom_range(0, 3) != 0);
         up         = $urandom_range(0, 1) == 1;
         gray_ready = $urandom_range(0, 1) == 1;
         load       = ($urandom_range(0, 31) == 0);
         load_bin   = W'($urandom_range(0, MOD - 1));
         p_valid = gray_valid; p_ready = gray_ready; p_load = load; p_gray = gray_out;
         cycle();
         vectors += 5;
         if (bin_out !== W'(m_bin)) begin miscompares++; $display("FAIL rnd_bin[%0d] got %0d want %0d", n, bin_out, m_bin); end
         if (gray_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", n, gray_valid, m_valid); end
         if (wrap !== m_wrap) begin miscompares++; $display("FAIL rnd_wrap[%0d] got %b want %b", n, wrap, m_wrap); end
         if (W'(gray_to_bin(gray_out)) !== bin_out) begin miscompares++; $display("FAIL rnd_decode[%0d] gray %b decodes %0d want %0d", n, gray_out, gray_to_bin(gray_out), bin_out); end
         if (p_valid && !gray_valid && !p_ready && !p_load) begin miscompares++; $display("FAIL rnd_valid_drop[%0d] got 0 want 1", n); end
         if (p_valid && !p_ready && !p_load) begin
            vectors++;
            if (gray_out !== p_gray) begin miscompares++; $display("FAIL rnd_stall_hold[%0d] got %b want %b", n, gray_out, p_gray); end
         end
      end
      load = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 0; up = 1; load = 0; load_bin = '0; gray_ready = 0;
      m_bin = 0; m_valid = 0; m_wrap = 0;
      @(negedge clk);
      test_reset();
      test_up_count();
      test_down_count();
      test_stall();
      test_load();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
